// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Define MULDIV_FAST_ZERO_EN to let PREP skip the loop for trivial operands.
module ex_muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;
  state_t state, state_nx;

  logic [1:0]          op_r;
  logic [DATA_W-1:0]   a_r, b_r;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opd;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r;

  logic                is_div, is_signed, sign_a, sign_b, shortcut;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum, div_sh;
  logic [DATA_W-1:0]   div_sub;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod, prod_fix;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign sign_a    = is_signed & a_r[DATA_W-1];
  assign sign_b    = is_signed & b_r[DATA_W-1];
  assign mag_a     = sign_a ? -a_r : a_r;
  assign mag_b     = sign_b ? -b_r : b_r;

  // Multiply: acc_lo holds the multiplier, product shifts right through acc_hi:acc_lo.
  // Divide: acc_hi is the partial remainder, quotient bits shift into acc_lo.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(DATA_W+1){1'b0}});
  assign div_sh   = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge   = div_sh >= {1'b0, opd};
  assign div_sub  = div_sh[DATA_W-1:0] - opd;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;

`ifdef MULDIV_FAST_ZERO_EN
  assign shortcut = is_div ? ((mag_b != '0) && (mag_b > mag_a))
                           : ((mag_a == '0) || (mag_b == '0));
`else
  assign shortcut = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !flush) state_nx = S_PREP;
      S_PREP:  state_nx = shortcut ? S_FIX : S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_r <= op;
            a_r  <= op_a;
            b_r  <= op_b;
          end
        end
        S_PREP: begin
          neg_q  <= sign_a ^ sign_b;
          neg_r  <= sign_a;
          acc_hi <= '0;
          acc_lo <= mag_a;
          opd    <= mag_b;
          cnt    <= CNT_W'(DATA_W);
          // Shortcut results are preloaded unsigned so FIX passes them through.
          if (shortcut) begin
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_lo <= '0;
            acc_hi <= is_div ? a_r : '0;
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc_hi <= div_ge ? div_sub : div_sh[DATA_W-1:0];
            acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[DATA_W:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          end
        end
        S_FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div && (b_r == '0)) begin
              hi <= a_r;
              lo <= {DATA_W{1'b1}};
            end else if (is_div) begin
              hi <= neg_r ? -acc_hi : acc_hi;
              lo <= neg_q ? -acc_lo : acc_lo;
            end else begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
